// File: rtl/input_debouncer.sv
// input_debouncer: two-channel synchroniser + glitch filter with registered rise/fall pulses
module input_debouncer #(
    parameter int STABLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic a_raw_in,
    input  logic b_raw_in,
    output logic a_out,
    output logic b_out,
    output logic a_rise_out,
    output logic a_fall_out,
    output logic b_rise_out,
    output logic b_fall_out
);
    localparam int CW = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
    typedef enum logic {STABLE, CHECK} state_t;
    logic [1:0] raw, out, rise, fall;
    assign raw = {b_raw_in, a_raw_in};
    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        state_t state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic out_q, out_d, rise_q, rise_d, fall_q, fall_d, s;
        assign s = sync_q[SYNC_STAGES-1];
        always_ff @(posedge clk_in) begin
            if (rst_in) begin
                sync_q  <= '0;
                state_q <= STABLE;
                cnt_q   <= '0;
                out_q   <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                sync_q  <= {sync_q[SYNC_STAGES-2:0], raw[c]};
                state_q <= state_d;
                cnt_q   <= cnt_d;
                out_q   <= out_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
            end
        end
        // any return of s to the current level restarts qualification from zero
        always_comb begin
            state_d = STABLE;
            cnt_d   = '0;
            out_d   = out_q;
            rise_d  = 1'b0;
            fall_d  = 1'b0;
            if (s != out_q) begin
                if (state_q == STABLE) begin
                    state_d = CHECK;
                    cnt_d   = CW'(1);
                end else if (cnt_q == LAST) begin
                    out_d  = s;
                    rise_d = s;
                    fall_d = ~s;
                end else begin
                    state_d = CHECK;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
        end
        assign out[c]  = out_q;
        assign rise[c] = rise_q;
        assign fall[c] = fall_q;
    end
    assign a_out      = out[0];
    assign b_out      = out[1];
    assign a_rise_out = rise[0];
    assign a_fall_out = fall[0];
    assign b_rise_out = rise[1];
    assign b_fall_out = fall[1];
endmodule

// File: doc/input_debouncer.md
# input_debouncer

Two-channel input conditioner that sits directly upstream of the two-input logic-operations stage and produces its `a_in` / `b_in` operands from raw, asynchronous, bouncy sources such as switches and push-buttons. Each channel is synchronised into the clock domain and then filtered by a small state machine. A channel's output changes only after the synchronised input has held a new level for a programmable number of consecutive cycles. The block also emits one-cycle rise and fall pulses for event-driven consumers.

## Interface
Parameters:
- `STABLE_CYCLES`, default 4: consecutive mismatching samples required before an output flips. Legal range is 2–255.
- `SYNC_STAGES`, default 2: synchroniser flop count per channel. Legal range is 2–3.

Ports:
- `clk_in`  input  1  single clock; all state updates on the rising edge
- `rst_in`  input  1  synchronous, active-high reset
- `a_raw_in`  input  1  raw asynchronous source, channel A
- `b_raw_in`  input  1  raw asynchronous source, channel B
- `a_out`  output  1  debounced level, channel A; drives `a_in` downstream
- `b_out`  output  1  debounced level, channel B; drives `b_in` downstream
- `a_rise_out`, `a_fall_out`  output  1 each  one-cycle edge pulses, channel A
- `b_rise_out`, `b_fall_out`  output  1 each  one-cycle edge pulses, channel B

## Operation
- The two channels are identical and fully independent. They share no counter or state.
- **Synchroniser:** a `SYNC_STAGES`-deep flop chain. Its last stage is `s`. No logic sits between the chain flops.
- **Counter:** `cnt` is ceil(log2(`STABLE_CYCLES`)) bits wide and unsigned. It never wraps: it is cleared before it can reach `STABLE_CYCLES`.
- **FSM states:** STABLE and CHECK.
- **STABLE:**
  - `s == out`: stay in STABLE, `cnt = 0`.
  - `s != out`: go to CHECK, `cnt = 1`.
- **CHECK:**
  - `s == out`: the change is treated as a glitch. Go to STABLE, `cnt = 0`, `out` unchanged, no pulse.
  - `s != out` and `cnt < STABLE_CYCLES-1`: `cnt` increments by 1.
  - `s != out` and `cnt == STABLE_CYCLES-1`: `out` takes the value of `s`, go to STABLE, `cnt = 0`, and fire the matching edge pulse.
- **Edge pulses:**
  - `x_rise_out` is asserted for exactly the one cycle in which `x_out` goes 0→1. `x_fall_out` behaves the same for 1→0.
  - Rise and fall of the same channel are never high together.
  - Pulses are registered outputs, not decoded from `out`.
- **Bouncing:** every return of `s` to the current `out` level restarts qualification from zero. There is no accumulation across bounces.
- **Both channels changing in the same cycle:** both qualify in parallel. The two outputs may flip in the same cycle.
- **Reset, all flops:** synchroniser flops = 0, `out` = 0, all pulses = 0, state = STABLE, `cnt` = 0.
- **Reset during CHECK:** the pending change is discarded. After reset is released, a source still high re-qualifies from scratch, with the full latency.

## Timing
- **Numbering:** edge 1 is the first rising edge at which a new raw level is sampled, meeting setup.
- **Latency:** `x_out` and its pulse update on edge `SYNC_STAGES + STABLE_CYCLES`. With the defaults this is edge 6.
- **Accepted pulse width:** a raw level held for ≥ `STABLE_CYCLES` samples is accepted. A level held for < `STABLE_CYCLES` samples is rejected.
- **Pulse width:** each edge pulse is exactly 1 cycle.
- **Back-to-back edges:** the minimum spacing between successive edge pulses on one channel is `STABLE_CYCLES` cycles.
- **Reset timing:**
  - `rst_in` sampled high on an edge forces all reset values at that edge.
  - `rst_in` takes priority over every transition.
  - Outputs are valid in the first cycle after reset deasserts.
- **Combinational paths:** there are none from any input to any output.

## Test plan
- **Reset values:** hold `rst_in` = 1 for 3 cycles with both raw inputs = 1 → all outputs = 0. Release reset → `a_out` = 1 and `b_out` = 1 at edge 6 after release, each with a single rise pulse.
- **Clean press (defaults):** `a_raw_in` goes 0→1 before edge 1 → `a_out` = 1 and `a_rise_out` = 1 at edge 6. `a_rise_out` = 0 at edge 7. B is untouched throughout.
- **Glitch threshold:** `a_raw_in` high for exactly 3 cycles → no output change, no pulse. High for exactly 4 cycles → `a_out` rises at edge 6, then `a_fall_out` fires 4 cycles later.
- **Bounce:** `a_raw_in` pattern 1,0,1,1,0,1,1,1,1 → `a_out` rises only after the final 4-cycle run. Exactly one `a_rise_out` pulse.
- **Simultaneous channels:** `a_raw_in` 0→1 and `b_raw_in` 0→1 on the same edge → `a_out`, `b_out`, `a_rise_out` and `b_rise_out` all assert on the same edge 6.
- **Reset during CHECK:** assert `rst_in` at edge 4 of an A transition → `a_out` stays 0 with no pulse. After release, with the source still high, `a_out` rises 6 edges later.
